// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the control FSM and the ALU: opcodes, ALU select
// codes, FSM state encoding and the decoded-instruction record.
package ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_NOT   = 6'h03;
    localparam logic [5:0] OP_AND   = 6'h04;
    localparam logic [5:0] OP_OR    = 6'h05;
    localparam logic [5:0] OP_SLL   = 6'h06;
    localparam logic [5:0] OP_SRL   = 6'h07;
    localparam logic [5:0] OP_LOADI = 6'h08;
    localparam logic [5:0] OP_SLT   = 6'h09;
    localparam logic [5:0] OP_BEQ   = 6'h0A;
    localparam logic [5:0] OP_BNE   = 6'h0B;
    localparam logic [5:0] OP_LW    = 6'h0C;
    localparam logic [5:0] OP_SW    = 6'h0D;
    localparam logic [5:0] OP_JMP   = 6'h0E;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_NOT   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_LOADI = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_BEQ   = 4'b1010;
    localparam logic [3:0] ALU_BNE   = 4'b1011;

    // Instruction class decides the path taken after DECODE.
    typedef enum logic [2:0] {
        CL_ALU,
        CL_BRANCH,
        CL_JMP,
        CL_LOAD,
        CL_STORE,
        CL_HALT,
        CL_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic [3:0] alu_sel;
        logic       alu_src_imm;
        op_class_t  op_class;
        logic       illegal;
    } decode_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/ctrl_fsm_opcode_decode.sv
// Combinational opcode decoder: ALU select, immediate-operand flag,
// instruction class and illegal-opcode flag.
module opcode_decode
    import ctrl_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    output decode_t    dec
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec.alu_sel     = ALU_NOP;
        dec.alu_src_imm = 1'b0;
        dec.op_class    = CL_ILLEGAL;
        dec.illegal     = 1'b0;
        case (opcode)
            OP_ADD:   begin dec.alu_sel = ALU_ADD;   dec.op_class = CL_ALU; end
            OP_SUB:   begin dec.alu_sel = ALU_SUB;   dec.op_class = CL_ALU; end
            OP_NOT:   begin dec.alu_sel = ALU_NOT;   dec.op_class = CL_ALU; end
            OP_AND:   begin dec.alu_sel = ALU_AND;   dec.op_class = CL_ALU; end
            OP_OR:    begin dec.alu_sel = ALU_OR;    dec.op_class = CL_ALU; end
            OP_SLL:   begin dec.alu_sel = ALU_SLL;   dec.op_class = CL_ALU; end
            OP_SRL:   begin dec.alu_sel = ALU_SRL;   dec.op_class = CL_ALU; end
            OP_LOADI: begin
                dec.alu_sel     = ALU_LOADI;
                dec.alu_src_imm = 1'b1;
                dec.op_class    = CL_ALU;
            end
            OP_SLT:   begin dec.alu_sel = ALU_SLT;   dec.op_class = CL_ALU; end
            OP_BEQ:   begin dec.alu_sel = ALU_BEQ;   dec.op_class = CL_BRANCH; end
            OP_BNE:   begin dec.alu_sel = ALU_BNE;   dec.op_class = CL_BRANCH; end
            OP_LW:    begin
                dec.alu_sel     = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.op_class    = CL_LOAD;
            end
            OP_SW:    begin
                dec.alu_sel     = ALU_ADD;
                dec.alu_src_imm = 1'b1;
                dec.op_class    = CL_STORE;
            end
            OP_JMP:   dec.op_class = CL_JMP;
            OP_HALT:  dec.op_class = CL_HALT;
            default:  dec.illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle instruction control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB),
// with memory timeout, illegal-opcode trap and a sticky HALT state.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  alu_sel,
    output logic        alu_src_imm,
    input  logic        alu_branch,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        halted,
    output logic        err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state;
    state_t           next_state;
    logic [5:0]       opcode_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_wait;
    decode_t          dec;

    // Operand fields belong to the datapath; only the opcode is consumed here.
    logic unused_operand_bits;
    assign unused_operand_bits = ^instr[25:0];

    opcode_decode u_decode (
        .opcode (opcode_q),
        .dec    (dec)
    );

    // Final MEM cycle before timeout; an ack in this same cycle still wins.
    assign last_wait = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opcode_q    <= '0;
            alu_sel     <= ALU_NOP;
            alu_src_imm <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && instr_valid) begin
                opcode_q <= opcode_of(instr);
            end
            if (state == S_DECODE) begin
                alu_sel     <= dec.alu_sel;
                alu_src_imm <= dec.alu_src_imm;
            end
            wait_cnt <= (state == S_MEM && next_state == S_MEM) ? wait_cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (instr_valid) next_state = S_DECODE;
            S_DECODE: next_state = dec.illegal ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (dec.op_class)
                    CL_ALU:             next_state = S_WB;
                    CL_LOAD, CL_STORE:  next_state = S_MEM;
                    CL_HALT:            next_state = S_HALT;
                    default:            next_state = S_IDLE;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    next_state = (dec.op_class == CL_LOAD) ? S_WB : S_IDLE;
                end else if (last_wait) begin
                    next_state = S_IDLE;
                end
            end
            S_WB:     next_state = S_IDLE;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        reg_we      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;
        case (state)
            S_IDLE:   instr_ready = 1'b1;
            S_DECODE: begin
                err    = dec.illegal;
                pc_inc = dec.illegal;
            end
            S_EXEC: begin
                if (dec.op_class == CL_BRANCH) begin
                    pc_load = alu_branch;
                    pc_inc  = !alu_branch;
                end else if (dec.op_class == CL_JMP) begin
                    pc_load = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec.op_class == CL_STORE);
                if (mem_ack) begin
                    pc_inc = (dec.op_class == CL_STORE);
                end else if (last_wait) begin
                    err    = 1'b1;
                    pc_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_inc = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

endmodule
